codec_init_seq: RTL
===================

CODEC_INIT_SEQ -- requirements
Module: codec_init_seq

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h34, 8-bit I2C write address byte presented on i2c_addr.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, idle sys_clk cycles between completion of one write and issue of the next (legal range 1..65535).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000000, sys_clk cycles allowed per write before error (used only with REQ-026).
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 sys_clk  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 start  input  1  level; sampled in IDLE, DONE, ERROR to (re)run the sequence.
REQ-008 i2c_addr  output  8  device address byte for the downstream writer.
REQ-009 i2c_register  output  8  register byte for the downstream writer.
REQ-010 i2c_data  output  8  data byte for the downstream writer.
REQ-011 i2c_write  output  1  one-cycle write request to the downstream writer.
REQ-012 i2c_done  input  1  one-cycle completion pulse from the downstream writer.
REQ-013 busy  output  1  high while the sequence runs.
REQ-014 init_done  output  1  high after all entries written, until restart or reset.
REQ-015 error  output  1  high in ERROR state.
REQ-016 index  output  4  table entry currently issued/awaited.

Function
REQ-017 SHALL hold an 11-entry constant table of {register,data}: 0:{1E,00} 1:{0C,00} 2:{00,17} 3:{02,17} 4:{04,79} 5:{06,79} 6:{08,12} 7:{0A,00} 8:{0E,02} 9:{10,00} 10:{12,01} (hex; codec reset, power-up, line-in, headphone, paths, I2S slave 16-bit, sampling, activate).
REQ-018 SHALL implement states IDLE, ISSUE, WAIT, GAP, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR with start=1 at edge k -> ISSUE at edge k+1; index=0, busy=1, init_done=0, error=0 from edge k+1.
REQ-020 ISSUE: i2c_write=1 for exactly one cycle, i2c_register/i2c_data loaded from table[index]; next state WAIT unconditionally.
REQ-021 i2c_addr, i2c_register, i2c_data SHALL remain stable from ISSUE until i2c_done is sampled in WAIT.
REQ-022 WAIT: i2c_done=1 with index<10 -> GAP; with index=10 -> DONE (no gap); i2c_done outside WAIT is ignored.
REQ-023 GAP: counts GAP_CYCLES cycles, then index increments by 1 and state goes to ISSUE.
REQ-024 DONE: busy=0, init_done=1, index holds 10.
REQ-025 start while busy=1 SHALL be ignored; i2c_write never asserts outside ISSUE.

Reset
REQ-026 reset=1 at any edge, including mid-sequence, SHALL force IDLE with i2c_write=0, busy=0, init_done=0, error=0, index=0, i2c_addr=DEV_ADDR, i2c_register=0, i2c_data=0, counters=0; reset overrides start and i2c_done.

Configuration
REQ-027 Macro CODEC_INIT_TIMEOUT_EN defined: a 32-bit counter cleared in ISSUE, incremented in WAIT; reaching TIMEOUT_CYCLES without i2c_done -> ERROR (busy=0, error=1, index holds failing entry).
REQ-028 Macro CODEC_INIT_TIMEOUT_EN undefined: no counter, WAIT lasts indefinitely, error stays 0, ERROR unreachable.

Verification
REQ-029 Reset, start=1 one cycle, writer model returns i2c_done 100 cycles after each i2c_write -> exactly 11 write pulses with table bytes in order, i2c_addr=34, then init_done=1, busy=0.
REQ-030 GAP_CYCLES=16: i2c_done at edge m for index 3 -> next i2c_write at edge m+18 with index=4.
REQ-031 Spurious i2c_done pulse in IDLE and in GAP -> no state change, no extra write, index unchanged.
REQ-032 reset=1 for one cycle while WAIT at index 5 -> IDLE, all outputs at reset values next edge; new start reissues entry 0.
REQ-033 TIMEOUT_EN defined, TIMEOUT_CYCLES=1000, no i2c_done for entry 2 -> error=1, index=2 after 1000 WAIT cycles; start=1 restarts at entry 0 with error=0.
REQ-034 start held high throughout sequence -> single 11-write run; start still high in DONE -> sequence reruns from entry 0.

Source files
------------

// File: rtl/codec_init_seq.sv
// codec_init_seq: walks a fixed 11-entry {register,data} table and hands each
// entry to a downstream I2C byte writer, one write request per entry, with an
// idle gap between writes. All outputs are registered decodes of the FSM state
// and index, so they trail the state register by one clock.
//
// Ports
//   sys_clk      in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   level; (re)runs the sequence from IDLE, DONE or ERROR
//   i2c_addr     out  [7:0] device write address byte (DEV_ADDR)
//   i2c_register out  [7:0] register byte of the current entry
//   i2c_data     out  [7:0] data byte of the current entry
//   i2c_write    out  one-cycle write request
//   i2c_done     in   one-cycle completion pulse from the writer
//   busy         out  sequence running
//   init_done    out  whole table written
//   error        out  write timed out (only with CODEC_INIT_TIMEOUT_EN)
//   index        out  [3:0] table entry being issued/awaited
//
// Build option: define CODEC_INIT_TIMEOUT_EN to add a per-write watchdog of
// TIMEOUT_CYCLES clocks that parks the sequence in ERROR.
module codec_init_seq #(
  parameter logic [7:0]  DEV_ADDR       = 8'h34,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_register,
  output logic [7:0] i2c_data,
  output logic       i2c_write,
  input  logic       i2c_done,
  output logic       busy,
  output logic       init_done,
  output logic       error,
  output logic [3:0] index
);

  localparam int unsigned NUM_ENTRIES = 11;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned GAP_W       = 16;
  localparam int unsigned TO_W        = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [GAP_W-1:0] GAP_END  = GAP_W'(GAP_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;

  logic       r_write;
  logic       r_busy;
  logic       r_init_done;
  logic       r_error;
  logic [3:0] r_index;
  logic [7:0] r_addr;
  logic [7:0] r_register;
  logic [7:0] r_data;

`ifdef CODEC_INIT_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
`else
  // Timeout limit has no effect when the watchdog is compiled out.
  logic w_unused_timeout;
  assign w_unused_timeout = ^TO_W'(TIMEOUT_CYCLES);
`endif

  // Codec bring-up table: reset, power-up, line-in, headphone, paths,
  // I2S slave 16-bit, sampling, activate.
  function automatic logic [15:0] table_entry(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    table_entry = 16'h1E00;
      4'd1:    table_entry = 16'h0C00;
      4'd2:    table_entry = 16'h0017;
      4'd3:    table_entry = 16'h0217;
      4'd4:    table_entry = 16'h0479;
      4'd5:    table_entry = 16'h0679;
      4'd6:    table_entry = 16'h0812;
      4'd7:    table_entry = 16'h0A00;
      4'd8:    table_entry = 16'h0E02;
      4'd9:    table_entry = 16'h1000;
      4'd10:   table_entry = 16'h1201;
      default: table_entry = 16'h0000;
    endcase
  endfunction

  // State, index and counter registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_gap_cnt <= '0;
`ifdef CODEC_INIT_TIMEOUT_EN
      r_to_cnt  <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
`ifdef CODEC_INIT_TIMEOUT_EN
      r_to_cnt  <= w_to_cnt_nxt;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_gap_cnt_nxt = r_gap_cnt;
`ifdef CODEC_INIT_TIMEOUT_EN
    w_to_cnt_nxt  = r_to_cnt;
`endif
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state_nxt = S_ISSUE;
          w_idx_nxt   = '0;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
`ifdef CODEC_INIT_TIMEOUT_EN
        w_to_cnt_nxt = '0;
`endif
      end
      S_WAIT: begin
        if (i2c_done) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt   = S_GAP;
            w_gap_cnt_nxt = '0;
          end
        end
`ifdef CODEC_INIT_TIMEOUT_EN
        else if (r_to_cnt == TO_LAST) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_W'(1);
        end
`endif
      end
      S_GAP: begin
        // The entry edge counts as slot 0, so GAP_CYCLES full idle cycles
        // elapse before the move to ISSUE.
        if (r_gap_cnt == GAP_END) begin
          w_state_nxt   = S_ISSUE;
          w_idx_nxt     = r_idx + IDX_W'(1);
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the current state.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_write     <= 1'b0;
      r_busy      <= 1'b0;
      r_init_done <= 1'b0;
      r_error     <= 1'b0;
      r_index     <= '0;
      r_addr      <= DEV_ADDR;
      r_register  <= '0;
      r_data      <= '0;
    end else begin
      r_write     <= (r_state == S_ISSUE);
      r_busy      <= (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_GAP);
      r_init_done <= (r_state == S_DONE);
      r_error     <= (r_state == S_ERROR);
      r_index     <= r_idx;
      r_addr      <= DEV_ADDR;
      // Bytes change only when a new entry is issued, so they stay put for
      // the whole write.
      if (r_state == S_ISSUE) begin
        {r_register, r_data} <= table_entry(r_idx);
      end
    end
  end

  assign i2c_write    = r_write;
  assign busy         = r_busy;
  assign init_done    = r_init_done;
  assign error        = r_error;
  assign index        = r_index;
  assign i2c_addr     = r_addr;
  assign i2c_register = r_register;
  assign i2c_data     = r_data;

endmodule
